trig_readout: RTL

Multi-channel, parametrised trigger-level readout engine. Takes a per-channel trigger level and offset in ADC codes plus a per-channel vertical-scale index. Produces a sign glyph code and a packed BCD magnitude (scaled units) for the on-screen trigger annotation. Sits between the trigger/cursor control registers and the character/seven-segment renderer. Adds a sequential BCD conversion, a start/valid handshake and overflow saturation.

---
 rtl/trig_pkg.sv | 35 +++
 rtl/bin2bcd_seq.sv | 51 +++++
 rtl/trig_readout.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/trig_pkg.sv
// Shared types and constants for the trigger-level readout engine.
package trig_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ABS,
        MUL,
        CONV,
        DONE
    } state_e;

    localparam logic [4:0] SIGN_POS = 5'd16;
    localparam logic [4:0] SIGN_NEG = 5'd17;

    localparam int unsigned LUT_W = 32;

    // Units per ADC code for each vertical-scale index; 13..15 fall back to 20000.
    localparam logic [LUT_W-1:0] SCALE_LUT [16] = '{
        32'd20,    32'd40,     32'd100,    32'd200,
        32'd400,   32'd1000,   32'd2000,   32'd4000,
        32'd10000, 32'd20000,  32'd40000,  32'd100000,
        32'd200000, 32'd20000, 32'd20000,  32'd20000
    };

    // Largest value representable in the given number of decimal digits.
    function automatic logic [63:0] dec_max(input int unsigned digits);
        logic [63:0] v;
        v = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one binary bit per step, MSB first.
// A load already shifts in the MSB, so BIN_W-1 steps follow it (BIN_W >= 2).
module bin2bcd_seq #(
    parameter int unsigned BIN_W      = 32,
    parameter int unsigned BCD_DIGITS = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_i,
    input  logic                      step_i,
    input  logic [BIN_W-1:0]          bin_i,
    output logic [4*BCD_DIGITS-1:0]   bcd_o
);

    localparam int unsigned BCD_W = 4 * BCD_DIGITS;

    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [BCD_W-1:0] adj;

    // Add-3 correction on every digit >= 5, then shift the next binary bit in.
    always_comb begin
        adj   = bcd_q;
        bin_d = bin_q;
        bcd_d = bcd_q;
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        if (load_i) begin
            {bcd_d, bin_d} = {BCD_W'(0), bin_i} << 1;
        end else if (step_i) begin
            {bcd_d, bin_d} = {adj, bin_q} << 1;
        end
    end

    // Converter state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q <= '0;
            bcd_q <= '0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
        end
    end

    assign bcd_o = bcd_q;

endmodule

// File: rtl/trig_readout.sv
// Trigger-level readout: |trig-offset| x scale, converted to saturating BCD.
module trig_readout
    import trig_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned ADC_W  = 10,
    parameter int unsigned VAL_W  = 32,
    parameter int unsigned DIGITS = 8,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [CH_W-1:0]            ch_sel,
    input  logic [NUM_CH*ADC_W-1:0]    trig,
    input  logic [NUM_CH*ADC_W-1:0]    offset_in,
    input  logic [NUM_CH*4-1:0]        scale_in,
    output logic                       busy,
    output logic                       valid,
    output logic [4:0]                 trig_sign,
    output logic [4*DIGITS-1:0]        bcd,
    output logic                       ovf
);

    localparam int unsigned CNT_W   = $clog2(VAL_W + 1);
    localparam int unsigned BCD_W   = 4 * DIGITS;
    localparam int unsigned CBCD_W  = 4 * (DIGITS + 1);
    localparam logic [63:0] MAG_MAX = dec_max(DIGITS);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADC_W-1:0]     req_trig_q, req_trig_d;
    logic [ADC_W-1:0]     req_off_q, req_off_d;
    logic [3:0]           req_scale_q, req_scale_d;
    logic [ADC_W-1:0]     abs_q, abs_d;
    logic                 neg_q, neg_d;
    logic [VAL_W-1:0]     mag_q, mag_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic [4:0]           sign_q, sign_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic                 ovf_q, ovf_d;

    logic [ADC_W-1:0]     sel_trig, sel_off;
    logic [3:0]           sel_scale;
    logic                 sel_ok;
    logic [VAL_W-1:0]     prod_c;
    logic [CBCD_W-1:0]    conv_bcd;
    logic                 conv_load, conv_step;

    // Select the requested channel; an out-of-range index leaves sel_ok low.
    always_comb begin
        sel_trig  = '0;
        sel_off   = '0;
        sel_scale = '0;
        sel_ok    = 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (32'(ch_sel) == c) begin
                sel_ok    = 1'b1;
                sel_trig  = trig[c*ADC_W +: ADC_W];
                sel_off   = offset_in[c*ADC_W +: ADC_W];
                sel_scale = scale_in[c*4 +: 4];
            end
        end
    end

    // The single multiplier; its result is captured into mag_q and the converter.
    assign prod_c = VAL_W'(abs_q) * VAL_W'(SCALE_LUT[req_scale_q]);

    assign conv_load = (state_q == MUL);
    assign conv_step = (state_q == CONV) && (cnt_q != CNT_W'(VAL_W - 1));

    bin2bcd_seq #(
        .BIN_W      (VAL_W),
        .BCD_DIGITS (DIGITS + 1)
    ) u_bcd (
        .clk    (clk),
        .rst    (rst),
        .load_i (conv_load),
        .step_i (conv_step),
        .bin_i  (prod_c),
        .bcd_o  (conv_bcd)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_trig_d  = req_trig_q;
        req_off_d   = req_off_q;
        req_scale_d = req_scale_q;
        abs_d       = abs_q;
        neg_d       = neg_q;
        mag_d       = mag_q;
        valid_d     = 1'b0;
        sign_d      = sign_q;
        bcd_d       = bcd_q;
        ovf_d       = ovf_q;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start && sel_ok) begin
                    state_d     = ABS;
                    req_trig_d  = sel_trig;
                    req_off_d   = sel_off;
                    req_scale_d = sel_scale;
                end
            end
            ABS: begin
                neg_d   = (req_trig_q < req_off_q);
                abs_d   = (req_trig_q < req_off_q) ? (req_off_q - req_trig_q)
                                                   : (req_trig_q - req_off_q);
                state_d = MUL;
            end
            MUL: begin
                mag_d   = prod_c;
                cnt_d   = '0;
                state_d = CONV;
            end
            CONV: begin
                if (cnt_q == CNT_W'(VAL_W - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    valid_d = 1'b1;
                    sign_d  = neg_q ? SIGN_NEG : SIGN_POS;
                    // Overflow if the spare top digit is used or the value was
                    // too wide to survive the (DIGITS+1)-digit shift register.
                    if ((conv_bcd[CBCD_W-1 -: 4] != 4'd0) || (64'(mag_q) > MAG_MAX)) begin
                        ovf_d = 1'b1;
                        bcd_d = {DIGITS{4'h9}};
                    end else begin
                        ovf_d = 1'b0;
                        bcd_d = conv_bcd[BCD_W-1:0];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == ABS) || (state_d == MUL) || (state_d == CONV);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_trig_q  <= '0;
            req_off_q   <= '0;
            req_scale_q <= '0;
            abs_q       <= '0;
            neg_q       <= 1'b0;
            mag_q       <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            sign_q      <= SIGN_POS;
            bcd_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_trig_q  <= req_trig_d;
            req_off_q   <= req_off_d;
            req_scale_q <= req_scale_d;
            abs_q       <= abs_d;
            neg_q       <= neg_d;
            mag_q       <= mag_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            sign_q      <= sign_d;
            bcd_q       <= bcd_d;
            ovf_q       <= ovf_d;
        end
    end

    assign busy      = busy_q;
    assign valid     = valid_q;
    assign trig_sign = sign_q;
    assign bcd       = bcd_q;
    assign ovf       = ovf_q;

endmodule
